// File: rtl/ex_pkg.sv
// Shared pipeline field types for the execute stage and its neighbours.
// Latency: n/a (types only).
// Backpressure: n/a.
package ex_pkg;

  // Destination register file of an instruction.
  typedef enum logic {
    X_REG = 1'b0,
    F_REG = 1'b1
  } reg_bank_mux_t;

  // Memory access size.
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } data_type_t;

endpackage

// File: rtl/ex_stage.sv
// Execute stage: ID->EX register, ALU, single-cycle multiply, iterative divide.
// Latency: ALU/MUL result valid the cycle the op sits in EX; DIV/REM busy 33 cycles (1 on fast specials).
// Backpressure: stall_ex_i holds the EX register; busy_ex_o stalls IF/ID while the divider runs.
//
// Ports: clk_i/rst_i (async active-high); *_id_i fields from ID; *_ex_o fields to the
// EX->MEM register; stall_ex_i hold, flush_ex_i bubble; busy_ex_o divider occupied.
module ex_stage
  import ex_pkg::*;
#(
  parameter logic DIV_FAST_SPECIAL = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   rs1_data_id_i,
  input  logic [31:0]   rs2_data_id_i,
  input  logic [31:0]   imm_id_i,
  input  logic          alu_src_imm_id_i,
  input  logic [4:0]    alu_op_id_i,
  input  logic [4:0]    rd_addr_id_i,
  input  reg_bank_mux_t rd_dst_bank_id_i,
  input  logic          mem_wen_id_i,
  input  logic          mem_sign_extend_id_i,
  input  logic          reg_alu_wen_id_i,
  input  logic          reg_mem_wen_id_i,
  input  logic          valid_id_i,
  input  data_type_t    mem_data_type_id_i,
  input  logic          stall_ex_i,
  input  logic          flush_ex_i,
  output logic [4:0]    rd_addr_ex_o,
  output reg_bank_mux_t rd_dst_bank_ex_o,
  output logic [31:0]   alu_result_ex_o,
  output logic          mem_wen_ex_o,
  output data_type_t    mem_data_type_ex_o,
  output logic          mem_sign_extend_ex_o,
  output logic [31:0]   mem_wdata_ex_o,
  output logic          reg_alu_wen_ex_o,
  output logic          reg_mem_wen_ex_o,
  output logic          valid_ex_o,
  output logic          busy_ex_o
);

  localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
  localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
  localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14;
  localparam logic [4:0] OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  // EX pipeline register
  logic [31:0]   r_a, r_b, r_rs2;
  logic [4:0]    r_op, r_rd_addr;
  reg_bank_mux_t r_bank;
  data_type_t    r_mem_type;
  logic          r_mem_wen, r_mem_sext, r_reg_alu_wen, r_reg_mem_wen, r_valid;

  // Divider state
  div_state_t    r_div_state;
  logic [4:0]    r_cnt;
  logic [31:0]   r_quo, r_rem, r_dvs;
  logic          r_q_neg, r_r_neg;

  logic          w_busy, w_load, w_abort;
  logic          w_div_op, w_div_signed, w_div_start, w_fast;
  logic          w_a_neg, w_b_neg, w_b_zero, w_ovf, w_ge;
  logic [31:0]   w_abs_a, w_abs_b, w_diff, w_quo_fin, w_rem_fin, w_alu;
  logic [32:0]   w_shift;
  logic          w_a_sx, w_b_sx;
  logic [63:0]   w_mul_a, w_mul_b, w_prod;

  assign w_div_op     = (r_op >= OP_DIV) && (r_op <= OP_REMU);
  assign w_div_signed = (r_op == OP_DIV) || (r_op == OP_REM);
  assign w_div_start  = r_valid && w_div_op && (r_div_state == DIV_IDLE);
  assign w_busy       = w_div_start || (r_div_state == DIV_RUN);
  // A flush that is not stalled kills whatever is in EX, including a running divide.
  assign w_abort      = flush_ex_i && !stall_ex_i;
  assign w_load       = !stall_ex_i && (!w_busy || flush_ex_i);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_a           <= '0;
      r_b           <= '0;
      r_rs2         <= '0;
      r_op          <= OP_ADD;
      r_rd_addr     <= '0;
      r_bank        <= X_REG;
      r_mem_type    <= WORD;
      r_mem_wen     <= 1'b0;
      r_mem_sext    <= 1'b0;
      r_reg_alu_wen <= 1'b0;
      r_reg_mem_wen <= 1'b0;
      r_valid       <= 1'b0;
    end else if (w_load) begin
      // A bubble only kills the side-effect bits; data fields hold.
      r_mem_wen     <= mem_wen_id_i && !flush_ex_i;
      r_reg_alu_wen <= reg_alu_wen_id_i && !flush_ex_i;
      r_reg_mem_wen <= reg_mem_wen_id_i && !flush_ex_i;
      r_valid       <= valid_id_i && !flush_ex_i;
      if (!flush_ex_i) begin
        r_a        <= rs1_data_id_i;
        r_b        <= alu_src_imm_id_i ? imm_id_i : rs2_data_id_i;
        r_rs2      <= rs2_data_id_i;
        r_op       <= alu_op_id_i;
        r_rd_addr  <= rd_addr_id_i;
        r_bank     <= rd_dst_bank_id_i;
        r_mem_type <= mem_data_type_id_i;
        r_mem_sext <= mem_sign_extend_id_i;
      end
    end
  end

  // Divider operand preparation (magnitudes for signed ops)
  assign w_a_neg  = w_div_signed & r_a[31];
  assign w_b_neg  = w_div_signed & r_b[31];
  assign w_abs_a  = w_a_neg ? -r_a : r_a;
  assign w_abs_b  = w_b_neg ? -r_b : r_b;
  assign w_b_zero = (r_b == 32'd0);
  assign w_ovf    = w_div_signed && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_fast   = DIV_FAST_SPECIAL && (w_b_zero || w_ovf);

  // Restoring step: partial remainder is always < divisor, so 32 bits suffice
  // once the trial subtraction has been decided on the 33-bit shifted value.
  assign w_shift  = {r_rem, r_quo[31]};
  assign w_ge     = w_shift >= {1'b0, r_dvs};
  assign w_diff   = w_shift[31:0] - r_dvs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_div_state <= DIV_IDLE;
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dvs       <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
    end else begin
      case (r_div_state)
        DIV_IDLE: begin
          if (w_div_start && !w_abort) begin
            if (w_fast) begin
              r_quo       <= w_b_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
              r_rem       <= w_b_zero ? r_a : 32'd0;
              r_q_neg     <= 1'b0;
              r_r_neg     <= 1'b0;
              r_div_state <= DIV_DONE;
            end else begin
              r_quo       <= w_abs_a;
              r_rem       <= '0;
              r_dvs       <= w_abs_b;
              // Divide by zero must leave the all-ones quotient unnegated.
              r_q_neg     <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
              r_r_neg     <= w_a_neg;
              r_cnt       <= 5'd31;
              r_div_state <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          if (w_abort) begin
            r_div_state <= DIV_IDLE;
          end else begin
            r_rem <= w_ge ? w_diff : w_shift[31:0];
            r_quo <= {r_quo[30:0], w_ge};
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd0) r_div_state <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          if (!stall_ex_i) r_div_state <= DIV_IDLE;
        end
        default: r_div_state <= DIV_IDLE;
      endcase
    end
  end

  assign w_quo_fin = r_q_neg ? -r_quo : r_quo;
  assign w_rem_fin = r_r_neg ? -r_rem : r_rem;

  // 64-bit sign/zero-extended operands give the same high word as a 33x33 signed product.
  assign w_a_sx  = (r_op == OP_MULH) || (r_op == OP_MULHSU);
  assign w_b_sx  = (r_op == OP_MULH);
  assign w_mul_a = {{32{w_a_sx & r_a[31]}}, r_a};
  assign w_mul_b = {{32{w_b_sx & r_b[31]}}, r_b};
  assign w_prod  = w_mul_a * w_mul_b;

  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:    w_alu = r_a + r_b;
      OP_SUB:    w_alu = r_a - r_b;
      OP_SLL:    w_alu = r_a << r_b[4:0];
      OP_SLT:    w_alu = {31'd0, $signed(r_a) < $signed(r_b)};
      OP_SLTU:   w_alu = {31'd0, r_a < r_b};
      OP_XOR:    w_alu = r_a ^ r_b;
      OP_SRL:    w_alu = r_a >> r_b[4:0];
      OP_SRA:    w_alu = $unsigned($signed(r_a) >>> r_b[4:0]);
      OP_OR:     w_alu = r_a | r_b;
      OP_AND:    w_alu = r_a & r_b;
      OP_MUL:    w_alu = w_prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_alu = w_prod[63:32];
      OP_DIV, OP_DIVU: w_alu = w_quo_fin;
      OP_REM, OP_REMU: w_alu = w_rem_fin;
      default:   w_alu = '0;
    endcase
  end

  assign rd_addr_ex_o         = r_rd_addr;
  assign rd_dst_bank_ex_o     = r_bank;
  assign alu_result_ex_o      = w_alu;
  assign mem_data_type_ex_o   = r_mem_type;
  assign mem_sign_extend_ex_o = r_mem_sext;
  assign mem_wdata_ex_o       = r_rs2;
  // MEM sees a bubble for as long as the divider holds the instruction.
  assign mem_wen_ex_o         = r_mem_wen && !w_busy;
  assign reg_alu_wen_ex_o     = r_reg_alu_wen && !w_busy;
  assign reg_mem_wen_ex_o     = r_reg_mem_wen && !w_busy;
  assign valid_ex_o           = r_valid && !w_busy;
  assign busy_ex_o            = w_busy;

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [31:0]   rs1_data_id_i, rs2_data_id_i, imm_id_i;
  logic          alu_src_imm_id_i;
  logic [4:0]    alu_op_id_i, rd_addr_id_i;
  reg_bank_mux_t rd_dst_bank_id_i;
  logic          mem_wen_id_i, mem_sign_extend_id_i, reg_alu_wen_id_i, reg_mem_wen_id_i, valid_id_i;
  data_type_t    mem_data_type_id_i;
  logic          stall_ex_i, flush_ex_i;
  logic [4:0]    rd_addr_ex_o;
  reg_bank_mux_t rd_dst_bank_ex_o;
  logic [31:0]   alu_result_ex_o, mem_wdata_ex_o;
  logic          mem_wen_ex_o, mem_sign_extend_ex_o, reg_alu_wen_ex_o, reg_mem_wen_ex_o;
  logic          valid_ex_o, busy_ex_o;
  data_type_t    mem_data_type_ex_o;

  int n_checks = 0;
  int n_errors = 0;

  ex_stage #(.DIV_FAST_SPECIAL(1'b1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rs1_data_id_i(rs1_data_id_i), .rs2_data_id_i(rs2_data_id_i), .imm_id_i(imm_id_i),
    .alu_src_imm_id_i(alu_src_imm_id_i), .alu_op_id_i(alu_op_id_i), .rd_addr_id_i(rd_addr_id_i),
    .rd_dst_bank_id_i(rd_dst_bank_id_i), .mem_wen_id_i(mem_wen_id_i),
    .mem_sign_extend_id_i(mem_sign_extend_id_i), .reg_alu_wen_id_i(reg_alu_wen_id_i),
    .reg_mem_wen_id_i(reg_mem_wen_id_i), .valid_id_i(valid_id_i),
    .mem_data_type_id_i(mem_data_type_id_i), .stall_ex_i(stall_ex_i), .flush_ex_i(flush_ex_i),
    .rd_addr_ex_o(rd_addr_ex_o), .rd_dst_bank_ex_o(rd_dst_bank_ex_o),
    .alu_result_ex_o(alu_result_ex_o), .mem_wen_ex_o(mem_wen_ex_o),
    .mem_data_type_ex_o(mem_data_type_ex_o), .mem_sign_extend_ex_o(mem_sign_extend_ex_o),
    .mem_wdata_ex_o(mem_wdata_ex_o), .reg_alu_wen_ex_o(reg_alu_wen_ex_o),
    .reg_mem_wen_ex_o(reg_mem_wen_ex_o), .valid_ex_o(valid_ex_o), .busy_ex_o(busy_ex_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: RISC-V integer/M semantics computed with 64-bit arithmetic.
  function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  begin p = sa >>> b[4:0]; return p[31:0]; end
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin p = sa * sb; return p[31:0]; end
      5'd11: begin p = sa * sb; return p[63:32]; end
      5'd12: begin p = sa * ub; return p[63:32]; end
      5'd13: begin p = ua * ub; return p[63:32]; end
      5'd14: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      5'd15: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      5'd16: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      5'd17: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic drive_id(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic use_imm, input logic vld);
    alu_op_id_i          = op;
    rs1_data_id_i        = a;
    rs2_data_id_i        = b;
    imm_id_i             = imm;
    alu_src_imm_id_i     = use_imm;
    valid_id_i           = vld;
    reg_alu_wen_id_i     = vld;
    mem_wen_id_i         = 1'b0;
    reg_mem_wen_id_i     = 1'b0;
    rd_addr_id_i         = 5'd1;
    rd_dst_bank_id_i     = X_REG;
    mem_data_type_id_i   = WORD;
    mem_sign_extend_id_i = 1'b0;
  endtask

  // Issue one divide, then count busy cycles and capture the result cycle.
  task automatic run_div(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int n_busy, output logic bubble_ok,
                         output logic [31:0] res, output logic res_vld);
    drive_id(op, a, b, 32'd0, 1'b0, 1'b1);
    mem_wen_id_i     = 1'b1;
    reg_mem_wen_id_i = 1'b1;
    @(posedge clk_i); #1;
    drive_id(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    n_busy    = 0;
    bubble_ok = 1'b1;
    @(negedge clk_i);
    while (busy_ex_o === 1'b1 && n_busy < 100) begin
      n_busy++;
      if (valid_ex_o !== 1'b0 || mem_wen_ex_o !== 1'b0 ||
          reg_alu_wen_ex_o !== 1'b0 || reg_mem_wen_ex_o !== 1'b0) bubble_ok = 1'b0;
      @(negedge clk_i);
    end
    res     = alu_result_ex_o;
    res_vld = valid_ex_o;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    stall_ex_i = 1'b0;
    flush_ex_i = 1'b0;
    drive_id(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    n_checks++;
    if (rd_dst_bank_ex_o !== X_REG || mem_data_type_ex_o !== WORD) begin
      n_errors++;
      $display("FAIL reset_enums: got bank=%0d type=%0d expected 0/2", rd_dst_bank_ex_o, mem_data_type_ex_o);
    end
    n_checks++;
    if ({rd_addr_ex_o, alu_result_ex_o, mem_wdata_ex_o, mem_wen_ex_o, mem_sign_extend_ex_o,
         reg_alu_wen_ex_o, reg_mem_wen_ex_o, valid_ex_o, busy_ex_o} !== 75'd0) begin
      n_errors++;
      $display("FAIL reset_zero: result=%h wdata=%h rd=%0d valid=%b busy=%b expected all 0",
               alu_result_ex_o, mem_wdata_ex_o, rd_addr_ex_o, valid_ex_o, busy_ex_o);
    end
    rst_i = 1'b0;
  endtask

  task automatic test_directed_alu();
    drive_id(5'd0, 32'd5, 32'h0000_1234, 32'hFFFF_FFFD, 1'b1, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (alu_result_ex_o !== 32'd2 || valid_ex_o !== 1'b1 || mem_wdata_ex_o !== 32'h0000_1234) begin
      n_errors++;
      $display("FAIL add_imm: got res=%h vld=%b wdata=%h expected 2/1/1234", alu_result_ex_o, valid_ex_o, mem_wdata_ex_o);
    end
    drive_id(5'd7, 32'h8000_0000, 32'd4, 32'd0, 1'b0, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (alu_result_ex_o !== 32'hF800_0000) begin
      n_errors++;
      $display("FAIL sra: got %h expected f8000000", alu_result_ex_o);
    end
    drive_id(5'd11, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (alu_result_ex_o !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL mulh: got %h expected ffffffff", alu_result_ex_o);
    end
    drive_id(5'd13, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1);
    @(negedge clk_i);
    n_checks++;
    if (alu_result_ex_o !== 32'h0000_0001) begin
      n_errors++;
      $display("FAIL mulhu: got %h expected 00000001", alu_result_ex_o);
    end
  endtask

  task automatic test_random_alu();
    logic [4:0] op, e_op, e_rd;
    logic [31:0] a, b, imm, e_a, e_b, e_rs2;
    logic use_imm, e_mwen, e_sext, e_rawen, e_rmwen, e_vld;
    reg_bank_mux_t e_bank;
    data_type_t e_type;
    int errs = 0;
    for (int i = 0; i < 300; i++) begin
      do op = 5'($urandom_range(0, 31)); while (op >= 5'd14 && op <= 5'd17);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      imm = $urandom;
      use_imm = 1'($urandom_range(0, 1));
      drive_id(op, a, b, imm, use_imm, 1'($urandom_range(0, 1)));
      rd_addr_id_i         = 5'($urandom);
      rd_dst_bank_id_i     = reg_bank_mux_t'($urandom_range(0, 1));
      mem_data_type_id_i   = data_type_t'(2'($urandom_range(0, 2)));
      mem_sign_extend_id_i = 1'($urandom_range(0, 1));
      mem_wen_id_i         = 1'($urandom_range(0, 1));
      reg_alu_wen_id_i     = 1'($urandom_range(0, 1));
      reg_mem_wen_id_i     = 1'($urandom_range(0, 1));
      stall_ex_i = (i > 0) && ($urandom_range(0, 7) == 0);
      flush_ex_i = (i > 0) && ($urandom_range(0, 7) == 0);
      if (!stall_ex_i) begin
        e_mwen  = mem_wen_id_i && !flush_ex_i;
        e_rawen = reg_alu_wen_id_i && !flush_ex_i;
        e_rmwen = reg_mem_wen_id_i && !flush_ex_i;
        e_vld   = valid_id_i && !flush_ex_i;
        if (!flush_ex_i) begin
          e_op = op; e_a = a; e_b = use_imm ? imm : b; e_rs2 = b;
          e_rd = rd_addr_id_i; e_bank = rd_dst_bank_id_i;
          e_type = mem_data_type_id_i; e_sext = mem_sign_extend_id_i;
        end
      end
      @(negedge clk_i);
      n_checks++;
      if (alu_result_ex_o !== ref_alu(e_op, e_a, e_b)) begin
        n_errors++;
        if (errs++ < 8) $display("FAIL rand_alu op=%0d a=%h b=%h: got %h expected %h",
                                 e_op, e_a, e_b, alu_result_ex_o, ref_alu(e_op, e_a, e_b));
      end
      n_checks++;
      if ({rd_addr_ex_o, rd_dst_bank_ex_o, mem_data_type_ex_o, mem_sign_extend_ex_o, mem_wdata_ex_o,
           mem_wen_ex_o, reg_alu_wen_ex_o, reg_mem_wen_ex_o, valid_ex_o, busy_ex_o} !==
          {e_rd, e_bank, e_type, e_sext, e_rs2, e_mwen, e_rawen, e_rmwen, e_vld, 1'b0}) begin
        n_errors++;
        if (errs++ < 8) $display("FAIL rand_fields i=%0d: got rd=%0d wdata=%h wen=%b%b%b vld=%b busy=%b expected rd=%0d wdata=%h wen=%b%b%b vld=%b busy=0",
                                 i, rd_addr_ex_o, mem_wdata_ex_o, mem_wen_ex_o, reg_alu_wen_ex_o, reg_mem_wen_ex_o,
                                 valid_ex_o, busy_ex_o, e_rd, e_rs2, e_mwen, e_rawen, e_rmwen, e_vld);
      end
    end
    stall_ex_i = 1'b0;
    flush_ex_i = 1'b0;
  endtask

  task automatic test_div();
    logic [4:0] ops [4] = '{5'd14, 5'd16, 5'd15, 5'd14};
    logic [31:0] as [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd1234, 32'h8000_0000};
    logic [31:0] bs [4] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] ex [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
    int lat [4] = '{33, 33, 1, 1};
    int n;
    logic ok, v;
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      run_div(ops[i], as[i], bs[i], n, ok, r, v);
      n_checks++;
      if (n != lat[i] || !ok) begin
        n_errors++;
        $display("FAIL div_latency[%0d]: got busy=%0d bubble_ok=%b expected %0d/1", i, n, ok, lat[i]);
      end
      n_checks++;
      if (r !== ex[i] || v !== 1'b1) begin
        n_errors++;
        $display("FAIL div_result[%0d]: got %h vld=%b expected %h vld=1", i, r, v, ex[i]);
      end
    end
  endtask

  task automatic test_random_div();
    logic [4:0] op;
    logic [31:0] a, b, r;
    int n, exp_lat;
    logic ok, v;
    for (int i = 0; i < 16; i++) begin
      op = 5'($urandom_range(14, 17));
      a = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp_lat = (b == 32'd0 || ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 33;
      run_div(op, a, b, n, ok, r, v);
      n_checks++;
      if (r !== ref_alu(op, a, b) || n != exp_lat || !ok || v !== 1'b1) begin
        n_errors++;
        $display("FAIL rand_div op=%0d a=%h b=%h: got %h busy=%0d ok=%b vld=%b expected %h busy=%0d",
                 op, a, b, r, n, ok, v, ref_alu(op, a, b), exp_lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic first_busy;
    drive_id(5'd14, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    drive_id(5'd17, 32'd100, 32'd7, 32'd0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk_i);
    while (busy_ex_o === 1'b1 && n < 100) begin n++; @(negedge clk_i); end
    n_checks++;
    if (n != 33 || alu_result_ex_o !== 32'd14) begin
      n_errors++;
      $display("FAIL b2b_first: got busy=%0d res=%h expected 33/0000000e", n, alu_result_ex_o);
    end
    @(posedge clk_i); #1;
    drive_id(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(negedge clk_i);
    first_busy = busy_ex_o;
    n = 0;
    while (busy_ex_o === 1'b1 && n < 100) begin n++; @(negedge clk_i); end
    n_checks++;
    if (first_busy !== 1'b1 || n != 33 || alu_result_ex_o !== 32'd2 || valid_ex_o !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_second: got first_busy=%b busy=%0d res=%h vld=%b expected 1/33/00000002/1",
               first_busy, n, alu_result_ex_o, valid_ex_o);
    end
  endtask

  task automatic test_flush_div();
    drive_id(5'd14, 32'd1000, 32'd7, 32'd0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    drive_id(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (11) @(negedge clk_i);
    n_checks++;
    if (busy_ex_o !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_pre_busy: got %b expected 1", busy_ex_o);
    end
    flush_ex_i = 1'b1;
    @(negedge clk_i);
    flush_ex_i = 1'b0;
    n_checks++;
    if ({busy_ex_o, valid_ex_o, reg_alu_wen_ex_o, mem_wen_ex_o, reg_mem_wen_ex_o} !== 5'd0) begin
      n_errors++;
      $display("FAIL flush_abort: got busy=%b vld=%b wen=%b%b%b expected all 0",
               busy_ex_o, valid_ex_o, reg_alu_wen_ex_o, mem_wen_ex_o, reg_mem_wen_ex_o);
    end
    @(negedge clk_i);
    n_checks++;
    if (busy_ex_o !== 1'b0 || valid_ex_o !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_no_restart: got busy=%b vld=%b expected 0/0", busy_ex_o, valid_ex_o);
    end
  endtask

  task automatic test_stall_done();
    int n;
    logic stable;
    drive_id(5'd15, 32'd1000, 32'd3, 32'd0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    drive_id(5'd0, 32'd40, 32'd2, 32'd0, 1'b0, 1'b1);
    n = 0;
    @(negedge clk_i);
    while (busy_ex_o === 1'b1 && n < 100) begin n++; @(negedge clk_i); end
    n_checks++;
    if (n != 33) begin
      n_errors++;
      $display("FAIL stall_div_latency: got %0d expected 33", n);
    end
    stall_ex_i = 1'b1;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk_i);
      if (alu_result_ex_o !== 32'd333 || valid_ex_o !== 1'b1 || busy_ex_o !== 1'b0) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin
      n_errors++;
      $display("FAIL stall_done_hold: got res=%h vld=%b busy=%b expected 0000014d/1/0",
               alu_result_ex_o, valid_ex_o, busy_ex_o);
    end
    stall_ex_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (alu_result_ex_o !== 32'd42 || valid_ex_o !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_release: got res=%h vld=%b expected 0000002a/1", alu_result_ex_o, valid_ex_o);
    end
    drive_id(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_div();
    drive_id(5'd16, 32'd5000, 32'd9, 32'd0, 1'b0, 1'b1);
    @(posedge clk_i); #1;
    drive_id(5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    n_checks++;
    if (busy_ex_o !== 1'b0 || valid_ex_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_div: got busy=%b vld=%b expected 0/0", busy_ex_o, valid_ex_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    n_checks++;
    if (busy_ex_o !== 1'b0 || valid_ex_o !== 1'b0 || alu_result_ex_o !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_after: got busy=%b vld=%b res=%h expected 0/0/0", busy_ex_o, valid_ex_o, alu_result_ex_o);
    end
  endtask

  initial begin
    test_reset();
    test_directed_alu();
    test_random_alu();
    test_div();
    test_random_div();
    test_back_to_back();
    test_flush_div();
    test_stall_done();
    test_reset_mid_div();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-V pipeline.
- Registers the ID->EX pipeline fields and computes the ALU or M-extension result.
- Multiply is single-cycle; divide and remainder use an iterative unit that stalls the front of the pipeline.
- Outputs feed the MEM stage EX->MEM register directly.

Parameters:
- DIV_FAST_SPECIAL, 1, when 1, divide-by-zero and signed overflow complete without iterating.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- rs1_data_id_i  in  32  operand A
- rs2_data_id_i  in  32  operand B / store data
- imm_id_i  in  32  immediate
- alu_src_imm_id_i  in  1  1: operand B = imm
- alu_op_id_i  in  5  operation code, see Behaviour
- rd_addr_id_i  in  5  destination register
- rd_dst_bank_id_i  in  reg_bank_mux_t  destination bank
- mem_wen_id_i, mem_sign_extend_id_i, reg_alu_wen_id_i, reg_mem_wen_id_i, valid_id_i  in  1 each  control
- mem_data_type_id_i  in  data_type_t  access size
- rd_addr_ex_o, rd_dst_bank_ex_o, alu_result_ex_o(32), mem_wen_ex_o, mem_data_type_ex_o, mem_sign_extend_ex_o, mem_wdata_ex_o(32), reg_alu_wen_ex_o, reg_mem_wen_ex_o, valid_ex_o  out  to MEM stage
- busy_ex_o  out  1  divider occupied; the hazard unit stalls IF/ID on it
- stall_ex_i  in  1  hold the EX register
- flush_ex_i  in  1  insert a bubble

Behaviour:
- Reset:
  - all EX registers 0; rd_dst_bank X_REG; data type WORD.
  - divider FSM IDLE; busy_ex_o 0; valid_ex_o 0.
- EX register load:
  - Loads on a clock edge when !stall_ex_i && !busy_ex_o.
  - If flush_ex_i is also high, it clears only mem_wen, reg_alu_wen, reg_mem_wen and valid; the other fields keep their value.
  - Stall has priority over flush.
  - Flush while busy (and !stall_ex_i) aborts the divider to IDLE and loads the bubble.
- Operand selection: opB = alu_src_imm ? imm : rs2. mem_wdata_ex_o = registered rs2.
- alu_op encoding, op: result
  - 0 ADD: A+B; 1 SUB: A-B
  - 2 SLL, 6 SRL, 7 SRA: shift by B[4:0]
  - 3 SLT: signed A<B, result 0/1; 4 SLTU: unsigned A<B, result 0/1
  - 5 XOR, 8 OR, 9 AND: bitwise
  - 10 MUL: low 32 bits of the product
  - 11 MULH, 12 MULHSU, 13 MULHU: high 32 bits of the 64-bit product, 33x33 signed multiply with operand sign extension chosen per op
  - 14 DIV, 15 DIVU, 16 REM, 17 REMU: iterative divider
  - 18-31: result 0
- Combinational ops: result is valid in the same cycle the instruction sits in the EX register.
- Divider FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: a valid div op in the EX register with FSM in IDLE drives busy_ex_o=1 combinationally. Next edge: capture |A|, |B| and the result signs (unsigned ops: raw values); counter=31; go to RUN.
  - RUN: one restoring shift-subtract step per cycle; busy_ex_o=1. Counter==0 -> DONE.
  - DONE: busy_ex_o=0; corrected quotient or remainder drives alu_result_ex_o. Go to IDLE on the edge where !stall_ex_i (instruction advances). Hold in DONE while stalled.
  - Latency: busy for exactly 33 cycles (1 setup + 32 RUN), then 1 result cycle.
  - Back-to-back divides: the second one enters IDLE->RUN in the cycle after the first leaves.
- Special cases when DIV_FAST_SPECIAL=1 (go IDLE->DONE directly, busy for 1 cycle):
  - B==0: quotient 0xFFFFFFFF; remainder = A.
  - Signed A=0x80000000, B=0xFFFFFFFF: quotient 0x80000000; remainder 0.
- Result sign correction (signed ops):
  - quotient negated if sign(A) != sign(B).
  - remainder takes the sign of A.
- Outputs to MEM while busy_ex_o=1: valid_ex_o, mem_wen_ex_o, reg_alu_wen_ex_o and reg_mem_wen_ex_o are forced 0 (bubble). Otherwise they equal the EX register.
- Reset mid-divide: returns to IDLE immediately; no result is produced.

Test Plan:
- Reset: assert rst_i for 3 cycles -> all outputs 0, rd_dst_bank_ex_o=X_REG, busy_ex_o=0.
- ADD A=5, B=imm 0xFFFFFFFD -> alu_result_ex_o=2, valid_ex_o=1 one cycle after load. SRA A=0x80000000, B=4 -> 0xF8000000.
- MULH A=0xFFFFFFFF, B=2 -> 0xFFFFFFFF. MULHU with the same operands -> 0x00000001.
- DIV A=-7, B=2 -> busy for 33 cycles with valid_ex_o=0, then result 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF.
- DIVU B=0 -> 0xFFFFFFFF after a 1-cycle busy. DIV 0x80000000/-1 -> 0x80000000.
- Flush at RUN cycle 10 -> busy_ex_o drops next cycle, valid_ex_o=0, no writeback. stall_ex_i held for 5 cycles in DONE -> result stable, FSM stays in DONE.
